// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: FSM states, ALU opcodes and B-operand shifts.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_t;

endpackage

// File: rtl/alu_shift_unit.sv
// Combinational B-operand shifter followed by the ALU and its Z/N/V flag logic.
module alu_shift_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   opcode_i,
  input  logic [1:0]   shift_i,
  output logic [W-1:0] result_o,
  output logic         z_o,
  output logic         n_o,
  output logic         v_o
);

  logic [W-1:0] bsh;
  logic [W-1:0] res;
  logic         ovf;

  always_comb begin
    bsh = b_i;
    unique case (shift_t'(shift_i))
      SH_NONE: bsh = b_i;
      SH_LSL:  bsh = {b_i[W-2:0], 1'b0};
      SH_LSR:  bsh = {1'b0, b_i[W-1:1]};
      SH_ASR:  bsh = {b_i[W-1], b_i[W-1:1]};
      default: bsh = b_i;
    endcase
  end

  // Overflow: operands (after negating B for SUB) share a sign that the result lacks.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (opcode_t'(opcode_i))
      OP_ADD: begin
        res = a_i + bsh;
        ovf = (a_i[W-1] == bsh[W-1]) && (res[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        res = a_i - bsh;
        ovf = (a_i[W-1] != bsh[W-1]) && (res[W-1] != a_i[W-1]);
      end
      OP_AND: res = a_i & bsh;
      OP_NOT: res = ~bsh;
      default: res = '0;
    endcase
  end

  assign result_o = res;
  assign z_o      = (res == '0);
  assign n_o      = res[W-1];
  assign v_o      = ovf;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: reads two registers, runs one ALU op and writes the result back.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   opcode,
  input  logic [1:0]   shift,
  input  logic [2:0]   rd,
  input  logic [2:0]   rn,
  input  logic [2:0]   rm,
  input  logic [W-1:0] reg_rdata,
  output logic [2:0]   readnum,
  output logic [2:0]   writenum,
  output logic         write,
  output logic [W-1:0] reg_wdata,
  output logic         busy,
  output logic         done,
  output logic [2:0]   status
);

  state_t       state_q, state_d;
  logic [W-1:0] a_q, b_q, c_q;
  logic [1:0]   op_q, sh_q;
  logic [2:0]   rd_q, rn_q, rm_q;
  logic [2:0]   status_q;

  logic [W-1:0] alu_res;
  logic         alu_z, alu_n, alu_v;

  alu_shift_unit #(.W(W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .opcode_i (op_q),
    .shift_i  (sh_q),
    .result_o (alu_res),
    .z_o      (alu_z),
    .n_o      (alu_n),
    .v_o      (alu_v)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RD_A;
      S_RD_A:  state_d = S_RD_B;
      S_RD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_q     <= '0;
      sh_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: if (start) begin
          op_q <= opcode;
          sh_q <= shift;
          rd_q <= rd;
          rn_q <= rn;
          rm_q <= rm;
        end
        S_RD_A: a_q <= reg_rdata;
        S_RD_B: b_q <= reg_rdata;
        S_EXEC: begin
          c_q      <= alu_res;
          status_q <= {alu_z, alu_n, alu_v};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readnum = '0;
    unique case (state_q)
      S_RD_A:  readnum = rn_q;
      S_RD_B:  readnum = rm_q;
      default: readnum = '0;
    endcase
  end

  assign write     = (state_q == S_WB);
  assign writenum  = write ? rd_q : '0;
  assign reg_wdata = write ? c_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign status    = status_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: behavioural 8x16 regfile, expected writebacks queued at issue and checked on write.
module tb_alu_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   opcode = '0;
  logic [1:0]   shift = '0;
  logic [2:0]   rd = '0, rn = '0, rm = '0;
  logic [W-1:0] reg_rdata;
  logic [2:0]   readnum, writenum;
  logic         write;
  logic [W-1:0] reg_wdata;
  logic         busy, done;
  logic [2:0]   status;

  alu_sequencer #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .shift     (shift),
    .rd        (rd),
    .rn        (rn),
    .rm        (rm),
    .reg_rdata (reg_rdata),
    .readnum   (readnum),
    .writenum  (writenum),
    .write     (write),
    .reg_wdata (reg_wdata),
    .busy      (busy),
    .done      (done),
    .status    (status)
  );

  always #5 clk = ~clk;

  logic [W-1:0] rf [8];
  logic         pl_en = 1'b0;
  logic [2:0]   pl_idx = '0;
  logic [W-1:0] pl_val = '0;
  int           wr_count = 0;
  int           done_count = 0;

  assign reg_rdata = rf[readnum];

  always @(posedge clk) begin
    if (write) begin
      rf[writenum] <= reg_wdata;
      wr_count++;
    end else if (pl_en) begin
      rf[pl_idx] <= pl_val;
    end
    if (done) done_count++;
  end

  typedef struct {
    logic [2:0]   wn;
    logic [W-1:0] wd;
    logic [2:0]   st;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] exp_rf [8];
  int           chk_cnt = 0;
  int           pass_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Reference model uses signed integer arithmetic for overflow detection.
  function automatic logic [W+2:0] model(input logic [1:0] op, input logic [1:0] sh,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] bs, r;
    logic v;
    int sa, sb2, s;
    case (sh)
      2'b01:   bs = W'(b * 2);
      2'b10:   bs = b / 2;
      2'b11:   bs = W'($signed(b) >>> 1);
      default: bs = b;
    endcase
    sa  = int'($signed(a));
    sb2 = int'($signed(bs));
    v = 1'b0;
    case (op)
      2'b00: begin s = sa + sb2; r = W'(s); v = (s > 32767) || (s < -32768); end
      2'b01: begin s = sa - sb2; r = W'(s); v = (s > 32767) || (s < -32768); end
      2'b10: r = a & bs;
      default: r = ~bs;
    endcase
    return {(r == 0), r[W-1], v, r};
  endfunction

  task automatic set_reg(input logic [2:0] idx, input logic [W-1:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
    exp_rf[idx] = val;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sh,
                       input logic [2:0] d, input logic [2:0] n, input logic [2:0] m);
    @(negedge clk);
    opcode = op; shift = sh; rd = d; rn = n; rm = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    opcode = ~op; shift = ~sh; rd = ~d; rn = ~n; rm = ~m;
  endtask

  // pulse_at: cycle whose ending edge sees a stray start (0 = none).
  task automatic run(input string nm, input logic [1:0] op, input logic [1:0] sh,
                     input logic [2:0] d, input logic [2:0] n, input logic [2:0] m,
                     input int pulse_at);
    logic [W+2:0] mr;
    exp_t e, g;
    int w0, d0;
    mr = model(op, sh, exp_rf[n], exp_rf[m]);
    e.wn = d; e.wd = mr[W-1:0]; e.st = mr[W+2:W];
    sb.push_back(e);
    w0 = wr_count; d0 = done_count;
    issue(op, sh, d, n, m);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      chk({nm, ".busy"}, 32'(busy), 32'(cyc <= 5));
      chk({nm, ".write"}, 32'(write), 32'(cyc == 4));
      chk({nm, ".done"}, 32'(done), 32'(cyc == 5));
      if (cyc == 1) chk({nm, ".readnum_a"}, 32'(readnum), 32'(n));
      if (cyc == 2) chk({nm, ".readnum_b"}, 32'(readnum), 32'(m));
      if (cyc == 3) chk({nm, ".readnum_exec"}, 32'(readnum), 32'd0);
      if (write) begin
        if (sb.size() == 0) begin
          chk({nm, ".sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
          g = sb.pop_front();
          chk({nm, ".writenum"}, 32'(writenum), 32'(g.wn));
          chk({nm, ".wdata"}, 32'(reg_wdata), 32'(g.wd));
        end
      end
      if (cyc == 5) chk({nm, ".status"}, 32'(status), 32'(e.st));
      if (cyc == pulse_at) begin
        opcode = 2'b11; shift = 2'b00; rd = 3'd0; rn = 3'd0; rm = 3'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, ".write_count"}, 32'(wr_count - w0), 32'd1);
    chk({nm, ".done_count"}, 32'(done_count - d0), 32'd1);
    exp_rf[d] = e.wd;
    chk({nm, ".rf_dest"}, 32'(rf[d]), 32'(e.wd));
    chk({nm, ".sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w0, d0;
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;

    reset = 1'b1;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.write", 32'(write), 32'd0);
    chk("rst.readnum", 32'(readnum), 32'd0);
    chk("rst.writenum", 32'(writenum), 32'd0);
    chk("rst.wdata", 32'(reg_wdata), 32'd0);
    chk("rst.status", 32'(status), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 3'(i); pl_val = '0;
    end
    @(negedge clk);
    pl_en = 1'b0;
    reset = 1'b0;

    set_reg(3'd1, 16'd7);
    set_reg(3'd2, 16'd2);
    run("add", 2'b00, 2'b00, 3'd3, 3'd1, 3'd2, 0);

    set_reg(3'd1, 16'd2);
    run("sub_zero_pulse_rdb", 2'b01, 2'b00, 3'd4, 3'd1, 3'd2, 2);

    set_reg(3'd1, 16'h7FFF);
    set_reg(3'd2, 16'd1);
    run("add_ovf_pulse_done", 2'b00, 2'b00, 3'd5, 3'd1, 3'd2, 5);

    w0 = wr_count; d0 = done_count;
    issue(2'b00, 2'b00, 3'd6, 3'd1, 3'd2);
    repeat (3) @(negedge clk);
    chk("abort.pre_status", 32'(status), 32'b011);
    reset = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.write", 32'(write), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.readnum", 32'(readnum), 32'd0);
    chk("abort.writenum", 32'(writenum), 32'd0);
    chk("abort.wdata", 32'(reg_wdata), 32'd0);
    chk("abort.status", 32'(status), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort.write_count", 32'(wr_count - w0), 32'd0);
    chk("abort.done_count", 32'(done_count - d0), 32'd0);
    chk("abort.busy_after", 32'(busy), 32'd0);
    chk("abort.rf6", 32'(rf[6]), 32'(exp_rf[6]));

    set_reg(3'd2, 16'h8002);
    run("not_lsl", 2'b11, 2'b01, 3'd7, 3'd1, 3'd2, 0);
    chk("not_lsl.value", 32'(exp_rf[7]), 32'hFFFB);
    run("not_lsr", 2'b11, 2'b10, 3'd7, 3'd1, 3'd2, 0);
    chk("not_lsr.value", 32'(rf[7]), 32'hBFFE);
    run("not_asr", 2'b11, 2'b11, 3'd7, 3'd1, 3'd2, 0);
    chk("not_asr.value", 32'(rf[7]), 32'h3FFE);

    run("and_rd_eq_rn", 2'b10, 2'b00, 3'd1, 3'd1, 3'd2, 0);
    chk("and_rd_eq_rn.value", 32'(rf[1]), 32'h0002);
    set_reg(3'd0, 16'h00F0);
    set_reg(3'd3, 16'h4000);
    run("add_lsl_rd_eq_rm", 2'b00, 2'b01, 3'd3, 3'd0, 3'd3, 0);
    run("sub_asr_neg", 2'b01, 2'b11, 3'd5, 3'd0, 3'd2, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
